uart_rx_frame: RTL

//  UART receive framer; sits directly downstream of the baud-rate counter.

---
 rtl/uart_rx_frame.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// UART 8N1 receive framer: synchronizes rx, detects the start edge, enables the
// external baud counter and assembles the frame LSB first on each mid-bit pulse.
module uart_rx_frame #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 bps_sig,
    output logic                 cnt_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic rx_m, rx_s, rx_s_d;
    logic start_edge;

    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [DATA_BITS-1:0] rx_data_nx;
    logic                 cnt_start_nx;
    logic                 rx_valid_nx;
    logic                 frame_err_nx;
    logic                 busy_nx;

    // Synchronizer and edge flop idle high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    assign start_edge = rx_s_d & ~rx_s;

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        shift_nx     = shift;
        rx_data_nx   = rx_data;
        cnt_start_nx = cnt_start;
        rx_valid_nx  = 1'b0;
        frame_err_nx = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nx     = START;
                    cnt_start_nx = 1'b1;
                end
            end
            START: begin
                if (bps_sig) begin
                    if (!rx_s) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end else begin
                        state_nx     = IDLE;
                        cnt_start_nx = 1'b0;
                    end
                end
            end
            DATA: begin
                if (bps_sig) begin
                    shift_nx   = {rx_s, shift[DATA_BITS-1:1]};
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit keeps a start edge at the stop-bit end catchable
                if (bps_sig) begin
                    if (rx_s) begin
                        rx_data_nx  = shift;
                        rx_valid_nx = 1'b1;
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                    state_nx     = IDLE;
                    cnt_start_nx = 1'b0;
                end
            end
            default: begin
                state_nx     = IDLE;
                cnt_start_nx = 1'b0;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_data   <= '0;
            cnt_start <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            rx_data   <= rx_data_nx;
            cnt_start <= cnt_start_nx;
            rx_valid  <= rx_valid_nx;
            frame_err <= frame_err_nx;
            busy      <= busy_nx;
        end
    end

    // Shift register is pure datapath; its contents only matter after DATA_BITS samples
    always_ff @(posedge clk) begin
        shift <= shift_nx;
    end

endmodule
